// File: rtl/seg_hex_pkg.sv
// Shared constants and types for the 7-segment display sequencer.
// The segment table is active-high in the {g,f,e,d,c,b,a} order. Board polarity is applied later.
package seg_hex_pkg;

    localparam logic [15:0] BASE_ADDR_DEFAULT = 16'h03FC;

    localparam int         SEG_DP_BIT = 7;
    localparam logic [6:0] SEG_BLANK  = 7'h00;

    // Entry n is the glyph for hex digit n; the leftmost element is index 15.
    localparam logic [15:0][6:0] SEG_HEX_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WR   = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

endpackage

// File: rtl/hex_to_seg.sv
// Converts one nibble to a segment byte {dp,g,f,e,d,c,b,a}.
// The byte can be blanked and inverted for common-anode boards.
module hex_to_seg
    import seg_hex_pkg::*;
(
    input  logic [3:0] i_nibble,
    input  logic       i_dp,
    input  logic       i_blank,
    input  logic       i_active_low,
    output logic [7:0] o_seg
);

    logic [7:0] w_seg_ah;

    // A blanked digit still shows its decimal point.
    always_comb begin
        w_seg_ah             = 8'h00;
        w_seg_ah[6:0]        = i_blank ? SEG_BLANK : SEG_HEX_TABLE[i_nibble];
        w_seg_ah[SEG_DP_BIT] = i_dp;
    end

    assign o_seg = i_active_low ? ~w_seg_ah : w_seg_ah;

endmodule

// File: rtl/seg_hex_ctrl.sv
// Display sequencer: writes four digit bytes to the LED peripheral.
// It shares the peripheral's single write port with the CPU, and the CPU always wins.
module seg_hex_ctrl
    import seg_hex_pkg::*;
#(
    parameter logic [15:0] BASE_ADDR      = BASE_ADDR_DEFAULT,
    parameter logic        SEG_ACTIVE_LOW = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [15:0] req_value,
    input  logic [3:0]  req_dp,
    input  logic        req_blank_lz,
    input  logic        cpu_we,
    input  logic [15:0] cpu_addr,
    input  logic [15:0] cpu_wdata,
    output logic        led_we,
    output logic [15:0] led_addr,
    output logic [15:0] led_in,
    output logic        busy,
    output logic        done,
    output logic [7:0]  conflict_cnt
);

    seq_state_t  r_state;
    seq_state_t  w_state_next;
    logic [1:0]  r_idx;
    logic [15:0] r_value;
    logic [3:0]  r_dp;
    logic        r_blank_lz;
    logic [7:0]  r_conflict_cnt;

    logic [7:0]  w_digit_seg [4];
    logic [3:0]  w_digit_blank;

    // Digit i is blank when it and every digit above it are zero. Digit 0 is never blank.
    for (genvar gi = 0; gi < 4; gi++) begin : g_digit
        if (gi == 0) begin : g_first
            assign w_digit_blank[gi] = 1'b0;
        end else begin : g_upper
            assign w_digit_blank[gi] = r_blank_lz && (r_value[15:4*gi] == '0);
        end

        hex_to_seg u_hex (
            .i_nibble     (r_value[4*gi +: 4]),
            .i_dp         (r_dp[gi]),
            .i_blank      (w_digit_blank[gi]),
            .i_active_low (SEG_ACTIVE_LOW),
            .o_seg        (w_digit_seg[gi])
        );
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_idx          <= 2'd0;
            r_value        <= 16'h0000;
            r_dp           <= 4'h0;
            r_blank_lz     <= 1'b0;
            r_conflict_cnt <= 8'h00;
        end else begin
            r_state <= w_state_next;
            if (r_state == ST_IDLE && req_valid) begin
                r_value    <= req_value;
                r_dp       <= req_dp;
                r_blank_lz <= req_blank_lz;
                r_idx      <= 2'd0;
            end
            if (r_state == ST_WR) begin
                if (cpu_we) begin
                    if (r_conflict_cnt != 8'hFF) begin
                        r_conflict_cnt <= r_conflict_cnt + 8'd1;
                    end
                end else begin
                    r_idx <= r_idx + 2'd1;
                end
            end
        end
    end

    // The write port is combinational, so CPU stores reach the peripheral in the same cycle.
    always_comb begin
        w_state_next = r_state;
        req_ready    = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        led_we       = 1'b0;
        led_addr     = 16'h0000;
        led_in       = 16'h0000;

        case (r_state)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_state_next = ST_WR;
                end
            end
            ST_WR: begin
                busy = 1'b1;
                if (!cpu_we) begin
                    led_we   = 1'b1;
                    led_addr = BASE_ADDR + {14'd0, r_idx};
                    led_in   = {8'h00, w_digit_seg[r_idx]};
                    if (r_idx == 2'd3) begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase

        if (cpu_we) begin
            led_we   = 1'b1;
            led_addr = cpu_addr;
            led_in   = cpu_wdata;
        end
    end

    assign conflict_cnt = r_conflict_cnt;

endmodule

// File: tb/tb_seg_hex_ctrl.sv
// Self-checking bench for seg_hex_ctrl: directed vectors, arbitration, reset abort and random sequences.
// Expected values come from the digit-table model and from the cycle rules below.
module tb_seg_hex_ctrl;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [15:0] req_value;
    logic [3:0]  req_dp;
    logic        req_blank_lz;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        led_we;
    logic [15:0] led_addr;
    logic [15:0] led_in;
    logic        busy;
    logic        done;
    logic [7:0]  conflict_cnt;

    int n_vec = 0;
    int n_err = 0;
    int m_conflict = 0;

    logic [7:0]  ref_tab [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                                  8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};
    logic [15:0] kn_val  [3] = '{16'h12AF, 16'h0030, 16'h0000};
    logic [3:0]  kn_dp   [3] = '{4'b0000, 4'b0000, 4'b0011};
    logic        kn_blz  [3] = '{1'b0, 1'b1, 1'b1};
    logic [7:0]  kn_data [3][4] = '{'{8'h8E, 8'h88, 8'hA4, 8'hF9},
                                    '{8'hC0, 8'hB0, 8'hFF, 8'hFF},
                                    '{8'h40, 8'h7F, 8'hFF, 8'hFF}};

    seg_hex_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_value    (req_value),
        .req_dp       (req_dp),
        .req_blank_lz (req_blank_lz),
        .cpu_we       (cpu_we),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .led_we       (led_we),
        .led_addr     (led_addr),
        .led_in       (led_in),
        .busy         (busy),
        .done         (done),
        .conflict_cnt (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Digit byte as the board sees it (active-low), built from the display rules.
    function automatic logic [7:0] model_seg(input logic [15:0] v, input logic [3:0] dp,
                                             input logic blz, input int d);
        int upper;
        int nib;
        int s;
        upper = int'(v) >> (4 * d);
        nib   = upper % 16;
        s     = (blz && d > 0 && upper == 0) ? 0 : int'(ref_tab[nib]);
        if (dp[d]) s = s + 128;
        return ~(8'(s));
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; req_valid = 1'b1; req_value = 16'($urandom);
        cpu_we = 1'b1; cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
        next_cycle(); next_cycle();
        @(negedge clk);
        n_vec++;
        if ({req_ready, busy, done, conflict_cnt} !== {1'b1, 1'b0, 1'b0, 8'h00} ||
            {led_we, led_addr, led_in} !== {1'b1, cpu_addr, cpu_wdata})
            begin n_err++; $display("FAIL reset_state: rdy=%b busy=%b done=%b cnt=%h led=%b/%h/%h, want 1 0 0 00 1/%h/%h",
                req_ready, busy, done, conflict_cnt, led_we, led_addr, led_in, cpu_addr, cpu_wdata); end
        cpu_we = 1'b0;
        #1;
        n_vec++;
        if ({led_we, led_addr, led_in} !== 33'd0)
            begin n_err++; $display("FAIL reset_idle_port: led=%b/%h/%h, want 0/0000/0000", led_we, led_addr, led_in); end
        next_cycle();
        rst_n = 1'b1; req_valid = 1'b0;
        m_conflict = 0;
    endtask

    task automatic test_known();
        for (int i = 0; i < 3; i++) begin
            next_cycle();
            req_valid = 1'b1; req_value = kn_val[i]; req_dp = kn_dp[i]; req_blank_lz = kn_blz[i]; cpu_we = 1'b0;
            next_cycle();
            req_valid = 1'b0;
            for (int c = 1; c <= 6; c++) begin
                if (c > 1) next_cycle();
                @(negedge clk);
                n_vec++;
                if (c <= 4) begin
                    if ({led_we, led_addr, led_in, busy} !== {1'b1, 16'h03FC + 16'(c - 1), 8'h00, kn_data[i][c-1], 1'b1})
                        begin n_err++; $display("FAIL known_write v=%h T+%0d: got %b %h:%h, want 1 %h:00%h",
                            kn_val[i], c, led_we, led_addr, led_in, 16'h03FC + 16'(c - 1), kn_data[i][c-1]); end
                end else if (c == 5) begin
                    if ({done, busy, req_ready, led_we} !== 4'b1000)
                        begin n_err++; $display("FAIL known_done v=%h: done=%b busy=%b rdy=%b we=%b, want 1 0 0 0",
                            kn_val[i], done, busy, req_ready, led_we); end
                end else begin
                    if ({req_ready, done, busy} !== 3'b100)
                        begin n_err++; $display("FAIL known_ready v=%h: rdy=%b done=%b busy=%b, want 1 0 0",
                            kn_val[i], req_ready, done, busy); end
                end
            end
            $display("known sequence value=%h checked", kn_val[i]);
        end
    endtask

    task automatic test_cpu_conflict();
        logic [15:0] ex_addr [5] = '{16'h03FC, 16'h1000, 16'h03FD, 16'h03FE, 16'h03FF};
        logic [15:0] ex_data [5] = '{16'h008E, 16'hBEEF, 16'h0088, 16'h00A4, 16'h00F9};
        next_cycle();
        req_valid = 1'b1; req_value = 16'h12AF; req_dp = 4'h0; req_blank_lz = 1'b0; cpu_we = 1'b0;
        next_cycle();
        req_valid = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            if (c > 1) next_cycle();
            cpu_we = (c == 2); cpu_addr = 16'h1000; cpu_wdata = 16'hBEEF;
            @(negedge clk);
            n_vec++;
            if (c <= 5) begin
                if ({led_we, led_addr, led_in} !== {1'b1, ex_addr[c-1], ex_data[c-1]})
                    begin n_err++; $display("FAIL conflict_write T+%0d: got %b %h:%h, want 1 %h:%h",
                        c, led_we, led_addr, led_in, ex_addr[c-1], ex_data[c-1]); end
            end else if (c == 6) begin
                m_conflict = (m_conflict < 255) ? m_conflict + 1 : 255;
                if ({done, busy, conflict_cnt} !== {1'b1, 1'b0, 8'(m_conflict)})
                    begin n_err++; $display("FAIL conflict_done: done=%b busy=%b cnt=%h, want 1 0 %h",
                        done, busy, conflict_cnt, 8'(m_conflict)); end
            end else begin
                if (req_ready !== 1'b1)
                    begin n_err++; $display("FAIL conflict_ready: rdy=%b, want 1", req_ready); end
            end
        end
        cpu_we = 1'b0;
        $display("conflict sequence checked, cnt=%h", conflict_cnt);
    endtask

    task automatic test_back_to_back();
        logic [15:0] va, vb;
        logic [3:0]  da, db;
        logic        ba, bb;
        va = 16'($urandom); vb = 16'($urandom) >> 8; da = 4'($urandom); db = 4'($urandom);
        ba = 1'($urandom); bb = 1'b1;
        next_cycle();
        req_valid = 1'b1; req_value = va; req_dp = da; req_blank_lz = ba; cpu_we = 1'b0;
        for (int c = 1; c <= 12; c++) begin
            next_cycle();
            if (c == 1) begin req_value = vb; req_dp = db; req_blank_lz = bb; end
            if (c == 7) req_valid = 1'b0;
            @(negedge clk);
            n_vec++;
            if (req_ready !== (c == 6 || c == 12) || done !== (c == 5 || c == 11))
                begin n_err++; $display("FAIL b2b_handshake T+%0d: rdy=%b done=%b, want %b %b",
                    c, req_ready, done, (c == 6 || c == 12), (c == 5 || c == 11)); end
            if (c == 1 || c == 7) begin
                n_vec++;
                if ({led_we, led_addr, led_in} !== {1'b1, 16'h03FC, 8'h00,
                        (c == 1) ? model_seg(va, da, ba, 0) : model_seg(vb, db, bb, 0)})
                    begin n_err++; $display("FAIL b2b_first_write T+%0d: got %b %h:%h, want 1 03fc:00%h",
                        c, led_we, led_addr, led_in,
                        (c == 1) ? model_seg(va, da, ba, 0) : model_seg(vb, db, bb, 0)); end
            end
        end
        $display("back-to-back requests %h then %h checked", va, vb);
    endtask

    // One request with CPU traffic; every cycle is checked against the write queue and handshake rules.
    task automatic run_seq(input logic [15:0] v, input logic [3:0] dp, input logic blz,
                           input int cpu_pct, input int stall_at, input int stall_len);
        int k;
        int cyc;
        logic [32:0] exp_port;
        next_cycle();
        req_valid = 1'b1; req_value = v; req_dp = dp; req_blank_lz = blz; cpu_we = 1'b0;
        @(negedge clk);
        n_vec++;
        if (req_ready !== 1'b1)
            begin n_err++; $display("FAIL seq_accept v=%h: rdy=%b, want 1", v, req_ready); end
        next_cycle();
        req_valid = 1'b0; req_value = 16'($urandom); req_dp = 4'($urandom); req_blank_lz = 1'($urandom);
        k = 0;
        cyc = 0;
        while (k < 4 && cyc < 1000) begin
            cpu_we = (cyc >= stall_at && cyc < stall_at + stall_len) ? 1'b1 : ($urandom_range(99) < cpu_pct);
            cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
            @(negedge clk);
            if (cpu_we) begin
                exp_port = {1'b1, cpu_addr, cpu_wdata};
                m_conflict = (m_conflict < 255) ? m_conflict + 1 : 255;
            end else begin
                exp_port = {1'b1, 16'h03FC + 16'(k), 8'h00, model_seg(v, dp, blz, k)};
                k++;
            end
            n_vec++;
            if ({led_we, led_addr, led_in} !== exp_port || {busy, req_ready, done} !== 3'b100)
                begin n_err++; $display("FAIL seq_port v=%h cyc%0d: got %b %h:%h b/r/d=%b%b%b, want %b %h:%h 100",
                    v, cyc, led_we, led_addr, led_in, busy, req_ready, done,
                    exp_port[32], exp_port[31:16], exp_port[15:0]); end
            next_cycle();
            cyc++;
        end
        if (k < 4) begin
            n_vec++; n_err++;
            $display("FAIL seq_timeout v=%h: %0d of 4 writes seen", v, k);
        end
        cpu_we = 1'($urandom); cpu_addr = 16'($urandom); cpu_wdata = 16'($urandom);
        @(negedge clk);
        n_vec++;
        if ({done, busy, req_ready} !== 3'b100 ||
            {led_we, led_addr, led_in} !== (cpu_we ? {1'b1, cpu_addr, cpu_wdata} : 33'd0))
            begin n_err++; $display("FAIL seq_done v=%h: d/b/r=%b%b%b we=%b %h:%h, want 100",
                v, done, busy, req_ready, led_we, led_addr, led_in); end
        next_cycle();
        cpu_we = 1'b0;
        @(negedge clk);
        n_vec++;
        if ({req_ready, done, busy, conflict_cnt} !== {3'b100, 8'(m_conflict)})
            begin n_err++; $display("FAIL seq_end v=%h: r/d/b=%b%b%b cnt=%h, want 100 %h",
                v, req_ready, done, busy, conflict_cnt, 8'(m_conflict)); end
        $display("seq value=%h dp=%b blz=%b cycles=%0d cnt=%h", v, dp, blz, cyc, conflict_cnt);
    endtask

    task automatic test_saturate();
        run_seq(16'($urandom), 4'($urandom), 1'($urandom), 0, 1, 300);
    endtask

    task automatic test_reset_abort();
        next_cycle();
        req_valid = 1'b1; req_value = 16'h12AF; req_dp = 4'h0; req_blank_lz = 1'b0; cpu_we = 1'b0;
        next_cycle();
        req_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            if (c > 1) next_cycle();
            if (c == 5) rst_n = 1'b1;
            @(negedge clk);
            n_vec++;
            if (c <= 2) begin
                if ({led_we, led_addr, led_in} !== {1'b1, 16'h03FC + 16'(c - 1), 8'h00, model_seg(16'h12AF, 4'h0, 1'b0, c - 1)})
                    begin n_err++; $display("FAIL abort_write T+%0d: got %b %h:%h", c, led_we, led_addr, led_in); end
                if (c == 2) rst_n = 1'b0;
            end else begin
                if ({led_we, done, busy, req_ready} !== 4'b0001)
                    begin n_err++; $display("FAIL abort_quiet T+%0d: we=%b done=%b busy=%b rdy=%b, want 0 0 0 1",
                        c, led_we, done, busy, req_ready); end
            end
        end
        m_conflict = 0;
        n_vec++;
        if (conflict_cnt !== 8'(m_conflict))
            begin n_err++; $display("FAIL abort_cnt: cnt=%h, want %h", conflict_cnt, 8'(m_conflict)); end
        $display("reset abort checked");
    endtask

    task automatic test_random();
        for (int i = 0; i < 25; i++) begin
            run_seq(16'($urandom) >> (4 * $urandom_range(0, 4)), 4'($urandom), 1'($urandom), 35, 0, 0);
        end
    endtask

    initial begin
        rst_n = 1'b0; req_valid = 1'b0; req_value = 16'h0; req_dp = 4'h0; req_blank_lz = 1'b0;
        cpu_we = 1'b0; cpu_addr = 16'h0; cpu_wdata = 16'h0;
        test_reset();
        test_known();
        test_cpu_conflict();
        test_back_to_back();
        test_saturate();
        test_reset_abort();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seg_hex_ctrl.md
Name: seg_hex_ctrl

Overview:
Display sequencer and write-port arbiter for the memory-mapped 4-digit 7-segment LED peripheral. It accepts a 16-bit value over a valid/ready handshake and converts each nibble to a segment byte. It then issues four single-cycle writes to the peripheral's digit registers at BASE..BASE+3. It shares the peripheral's single write port with the CPU store path, and the CPU always has priority.

Parameters:
BASE_ADDR, 16'h03FC, full 16-bit address of digit 0; digits 1..3 at BASE_ADDR+1..+3
SEG_ACTIVE_LOW, 1, 1 = invert all 8 segment bits before writing (common-anode board)

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
req_valid  in  1  display request valid
req_ready  out  1  block can accept a request
req_value  in  16  value to display; nibble i drives digit i
req_dp  in  4  decimal point enable per digit
req_blank_lz  in  1  1 = blank leading zero digits (digit 0 never blanked)
cpu_we  in  1  CPU store strobe
cpu_addr  in  16  CPU store address
cpu_wdata  in  16  CPU store data
led_we  out  1  peripheral write enable
led_addr  out  16  peripheral address
led_in  out  16  peripheral write data
busy  out  1  sequence in progress
done  out  1  one-cycle pulse after the 4th digit write
conflict_cnt  out  8  saturating count of cycles the sequencer was held off by the CPU

Behaviour:
- States: IDLE, WR, DONE. Digit index idx is 2 bits, and the request is captured in registers.
- IDLE: req_ready=1, busy=0. On req_valid&&req_ready, capture value, dp and blank_lz, set idx=0, and go to WR.
- WR: req_ready=0, busy=1.
  - Each cycle with cpu_we=0, drive led_we=1, led_addr=BASE_ADDR+idx, led_in={8'h00, seg(idx)}, and increment idx.
  - The write with idx=3 moves the FSM to DONE.
- Arbitration: when cpu_we=1 (any address), the CPU is granted: led_we=1, led_addr=cpu_addr, led_in=cpu_wdata.
  - The sequencer holds idx that cycle.
  - In WR, conflict_cnt increments; it saturates at 8'hFF and is cleared only by reset.
- Output mux: led_* are combinational from the registered state and the cpu_* inputs, so CPU writes reach the peripheral in the same cycle. When neither source drives, led_we=0, led_addr=0, led_in=0.
- DONE: done=1, busy=0, req_ready=0. Next cycle returns to IDLE.
- Uncontended latency: accept at cycle T, writes at T+1..T+4, done at T+5, req_ready at T+6.
- Segment byte: bit order {dp,g,f,e,d,c,b,a}. Active-high nibble table:
  - 0:3F 1:06 2:5B 3:4F 4:66 5:6D 6:7D 7:07
  - 8:7F 9:6F A:77 b:7C C:39 d:5E E:79 F:71
  - bit7 = dp[idx]; when SEG_ACTIVE_LOW=1, invert all 8 bits.
- Leading-zero blanking: when blank_lz=1, digit i (i>=1) is blanked if nibbles i..3 are all zero. A blanked digit has segment bits a..g off, and its dp bit is still honoured.
- Requests arriving while busy are not accepted (req_ready=0). The requester holds req_valid.
- Reset (rst_n=0 at a clock edge):
  - State forced to IDLE, idx=0, captured registers=0, conflict_cnt=0.
  - After reset: req_ready=1, busy=0, done=0.
  - A reset mid-sequence aborts it: no further sequencer writes and no done pulse.
  - The CPU pass-through stays combinational throughout.

Decomposition:
- Package seg_hex_pkg holds: the BASE_ADDR default, the 16-entry hex segment table constants, the blank/dp bit positions, and the FSM state enum (IDLE, WR, DONE).
- Sub-module hex_to_seg (combinational) takes nibble, dp, blank and active_low, and produces an 8-bit segment byte.
- The top level holds the FSM, idx, the conflict counter and the write-port mux.

Test Plan:
- Reset, then value=16'h12AF, dp=0, blank_lz=0, no CPU traffic. Required at T+1..T+4 (addr:data, active-low):
  - 03FC:008E, 03FD:0088, 03FE:00A4, 03FF:00F9
  - then done at T+5 and req_ready at T+6.
- value=16'h0030, blank_lz=1. Required writes:
  - 03FC:00C0, 03FD:00B0, 03FE:00FF, 03FF:00FF.
- value=16'h0000, dp=4'b0011, blank_lz=1. Required writes:
  - 03FC:0040 (digit 0 never blanked)
  - 03FD:007F (blank with dp), 03FE:00FF, 03FF:00FF.
- value=16'h12AF with cpu_we=1, addr=16'h1000, wdata=16'hBEEF at T+2. Required:
  - led_* = 1000/BEEF at T+2.
  - 03FD:0088 moves to T+3; last write at T+5, done at T+6; conflict_cnt=1.
- Second req_valid held from T+1 -> accepted only at T+6. Reset asserted at T+3 of a sequence -> no writes after T+2, no done, req_ready=1 after reset.
- cpu_we=1 for 300 consecutive cycles during WR -> no sequencer writes during the stall, conflict_cnt saturates at 8'hFF, and the sequence completes after cpu_we drops.
